// File: rtl/row_load_pkg.sv
// Shared defaults and state encoding for the row load sequencer.
package row_load_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int LANES_DEF = 10;
  localparam int ROWS_DEF  = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_WAIT
  } state_t;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/modn_counter.sv
// Modulo-N counter with clear, enable, wrap at N-1 and terminal count.
module modn_counter
  import row_load_pkg::*;
#(
  parameter int N = 10,
  parameter int W = cw(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/row_load_seq.sv
// Assembles a streamed matrix into rows and hands each row to a
// downstream register bank with a load strobe and consume handshake.
module row_load_seq
  import row_load_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = LANES_DEF,
  parameter int ROWS  = ROWS_DEF,
  localparam int LW   = cw(LANES),
  localparam int RW   = cw(ROWS)
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH*LANES-1:0] dout,
  output logic               ld,
  input  logic               consume,
  output logic [RW-1:0]      row_idx,
  output logic               busy,
  output logic               done
);

  state_t        state;
  logic [LW-1:0] lane_cnt;
  logic [RW-1:0] row_cnt;
  logic          lane_tc;
  logic          row_tc;
  logic          accept;
  logic          last_word;
  logic          row_step;
  logic          lane_clr;
  logic          row_clr;

  // in_ready is high exactly in FILL, so it doubles as the state qualifier
  assign accept    = in_ready & in_valid & ~abort;
  assign last_word = accept & lane_tc;
  assign row_step  = (state == S_WAIT) & consume & ~abort;
  assign lane_clr  = (state != S_FILL) | abort;
  assign row_clr   = (state == S_IDLE) | abort;
  assign row_idx   = row_cnt;

  modn_counter #(.N(LANES), .W(LW)) u_lane (
    .clk    (CLK),
    .reset  (reset),
    .clear  (lane_clr),
    .enable (accept),
    .cnt    (lane_cnt),
    .tc     (lane_tc)
  );

  // row counter wraps to zero on the final consume
  modn_counter #(.N(ROWS), .W(RW)) u_row (
    .clk    (CLK),
    .reset  (reset),
    .clear  (row_clr),
    .enable (row_step),
    .cnt    (row_cnt),
    .tc     (row_tc)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      ld       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
    end else begin
      ld   <= 1'b0;
      done <= 1'b0;
      if (accept) begin
        for (int k = 0; k < LANES; k++) begin
          if (lane_cnt == LW'(k)) begin
            dout[k*WIDTH +: WIDTH] <= in_data;
          end
        end
      end
      if (abort && state != S_IDLE) begin
        state    <= S_IDLE;
        in_ready <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_FILL;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
          S_FILL: begin
            if (last_word) begin
              state    <= S_LOAD;
              in_ready <= 1'b0;
              ld       <= 1'b1;
            end
          end
          S_LOAD: begin
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (row_step) begin
              if (row_tc) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state    <= S_FILL;
                in_ready <= 1'b1;
              end
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/row_load_seq.md
ROW_LOAD_SEQ -- requirements
Module: row_load_seq

Interface
REQ-001 Parameter WIDTH, default 16, bits per matrix element.
REQ-002 Parameter LANES, default 10, elements per row; equals the number of lanes in the downstream row register bank.
REQ-003 Parameter ROWS, default 10, rows per matrix transfer.
REQ-004 Port: CLK  input  1  single clock; all logic on posedge CLK.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  one-cycle request to begin a matrix transfer.
REQ-007 Port: abort  input  1  synchronous cancel of the transfer in progress.
REQ-008 Port: in_data  input  WIDTH  element stream.
REQ-009 Port: in_valid  input  1  in_data is valid.
REQ-010 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-011 Port: dout  output  WIDTH*LANES  assembled row; lane k occupies dout[WIDTH*k+WIDTH-1 : WIDTH*k], with lane 0 mapping to downstream Dout1.
REQ-012 Port: ld  output  1  one-cycle load strobe to the row register bank.
REQ-013 Port: consume  input  1  downstream pulse: the loaded row has been used.
REQ-014 Port: row_idx  output  clog2(ROWS)  index of the row being filled, loaded or awaited.
REQ-015 Port: busy  output  1  high in every state except IDLE.
REQ-016 Port: done  output  1  one-cycle pulse after the last row is consumed.

Function
REQ-017 The FSM SHALL have states IDLE, FILL, LOAD and WAIT.
REQ-018 IDLE: in_ready=0, ld=0; start=1 -> FILL with lane_cnt=0 and row_cnt=0.
REQ-019 FILL: in_ready=1; a word is accepted only when in_valid&in_ready, it is written to lane lane_cnt, and lane_cnt increments.
REQ-020 FILL: acceptance with lane_cnt==LANES-1 -> LOAD; the accepting cycle updates the final lane.
REQ-021 LOAD lasts exactly one cycle with ld=1 and in_ready=0, then -> WAIT; latency from the last word accepted to ld=1 is 1 cycle.
REQ-022 WAIT: in_ready=0; consume=1 -> if row_cnt==ROWS-1 then IDLE with done=1 for that transition cycle, else row_cnt+1 and FILL with lane_cnt=0.
REQ-023 consume SHALL be ignored outside WAIT, including during the LOAD cycle.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 abort=1 in any non-IDLE state -> IDLE next cycle; lane_cnt and row_cnt clear, no ld, no done; dout retains its contents.
REQ-026 abort has priority over consume, word acceptance and the LOAD transition in the same cycle.
REQ-027 dout SHALL be driven from flops, be unchanged from LOAD through WAIT, and change only lane-by-lane on accepted words.
REQ-028 ld is a posedge-registered output and is therefore stable at the downstream negedge capture.
REQ-029 row_idx = row_cnt; lane_cnt and row_cnt SHALL never exceed LANES-1 and ROWS-1 respectively.

Reset
REQ-030 reset=1 at a posedge -> IDLE, lane_cnt=0, row_cnt=0, dout=0, ld=0, in_ready=0, busy=0, done=0, row_idx=0.
REQ-031 reset overrides all inputs, including start, abort and in_valid, and applies in every state.

Structure
REQ-032 Shared package row_load_pkg SHALL hold the WIDTH/LANES/ROWS defaults and the state encoding.
REQ-033 Sub-module modn_counter (clear, enable, wrap at N-1, terminal-count output) SHALL be instantiated twice: once for lanes, once for rows.
REQ-034 There SHALL be no combinational path from in_valid or consume to ld or dout.

Verification
REQ-035 Stimulus: reset, start, then words 1..10 with in_valid held continuously. Required: in_ready=1 for 10 cycles; ld=1 exactly 1 cycle after word 10; dout lanes 0..9 = 1..10; row_idx=0.
REQ-036 Stimulus: full matrix of words 0..99 in 10 rows, consume pulsed 3 cycles after each ld. Required: 10 ld pulses; row_idx steps 0..9; done=1 for exactly one cycle after the 10th consume; busy=0 afterwards.
REQ-037 Stimulus: in_valid toggled 1,0,0,1 during FILL. Required: only cycles with in_valid&in_ready advance lane_cnt; ld is not asserted until 10 words are accepted.
REQ-038 Stimulus: abort after 5 words of row 3; then start again. Required: IDLE next cycle, no ld, no done; the new transfer restarts at row_idx=0, lane 0.
REQ-039 Stimulus: consume asserted during LOAD, and start asserted during FILL. Required: both ignored; the FSM stays in WAIT until a later consume.
REQ-040 Stimulus: reset asserted in WAIT with in_valid=1. Required: all outputs at reset values next cycle; in_ready stays 0 until the next start.
